// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing the single-ported unified memory between the IF and MEM stages.
// Define ARB_STARVE_GUARD_EN to bound how many dm grants may pass a pending IF request.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              gnt_dm,
   output logic              pipe_stall
);

   localparam int unsigned      LAT_W    = 8;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

   if (MEM_LAT < 1 || MEM_LAT > 255) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..255");
   end
   if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_MAX must be in 1..7");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state;
   logic [LAT_W-1:0] lat_cnt;
   logic             req_any;
   logic             sel_dm;

   assign req_any    = if_req | dm_req;
   assign pipe_stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   logic [2:0] starve_cnt;

   // dm keeps priority until it has passed a pending IF request STARVE_MAX times
   assign sel_dm = dm_req & ~(if_req & (starve_cnt == STARVE_LIM));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= 3'd0;
      end else if (state == S_IDLE && req_any) begin
         if (sel_dm && if_req) begin
            starve_cnt <= starve_cnt + 3'd1;
         end else begin
            starve_cnt <= 3'd0;
         end
      end
   end
`else
   // MEM-stage instruction is older, so dm always wins a tie
   assign sel_dm = dm_req;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         lat_cnt   <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         gnt_dm    <= 1'b0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         mem_en   <= 1'b0;
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_any) begin
                  state     <= S_ISSUE;
                  mem_en    <= 1'b1;
                  gnt_dm    <= sel_dm;
                  mem_we    <= sel_dm & dm_we;
                  mem_addr  <= sel_dm ? dm_addr : if_addr;
                  mem_wdata <= sel_dm ? dm_wdata : '0;
               end
            end
            S_ISSUE: begin
               state   <= S_WAIT;
               lat_cnt <= '0;
            end
            S_WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  state <= S_RESP;
                  if (gnt_dm) begin
                     dm_ready <= 1'b1;
                     if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                     end
                  end else begin
                     if_ready <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 5) share stimulus.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int          NI = 3;
   localparam logic [DW-1:0] POISON = 32'hBAD0_BAD0;

   typedef struct {
      logic          is_dm;
      logic [DW-1:0] data;
      int            rdy;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, dm_req, dm_we;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata;

   logic [DW-1:0] if_rdata  [NI];
   logic          if_ready  [NI];
   logic [DW-1:0] dm_rdata  [NI];
   logic          dm_ready  [NI];
   logic          mem_en    [NI];
   logic          mem_we    [NI];
   logic [AW-1:0] mem_addr  [NI];
   logic [DW-1:0] mem_wdata [NI];
   logic          gnt_dm    [NI];
   logic          pipe_stall[NI];

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      if (a == 32'h0040_0000) return 32'h2008_0005;
      return a ^ 32'h5A5A_5A5A;
   endfunction

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
      logic [DW-1:0] rdata_m;
      logic          act;
      int            age;
      logic [AW-1:0] a_l;

      mem_port_arbiter #(
         .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(4)
      ) dut (
         .clk(clk), .reset(reset),
         .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
         .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
         .dm_rdata(dm_rdata[g]), .dm_ready(dm_ready[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_rdata(rdata_m),
         .gnt_dm(gnt_dm[g]), .pipe_stall(pipe_stall[g])
      );

      // memory model: data valid only in the cycle MEM_LAT after the mem_en cycle
      always @(negedge clk or posedge reset) begin
         if (reset) begin
            act <= 1'b0;
            age <= 0;
            a_l <= '0;
         end else if (mem_en[g]) begin
            act <= 1'b1;
            age <= 0;
            a_l <= mem_addr[g];
         end else if (act) begin
            age <= age + 1;
         end
      end
      assign rdata_m = (act && age == LAT) ? mem_val(a_l) : POISON;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      sbq.delete();
   endtask

   task automatic test_reset();
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      reset = 1'b1;
      tick();
      #1;
      total++;
      if ({mem_en[0], mem_we[0], if_ready[0], dm_ready[0], gnt_dm[0]} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b exp=00000",
                  {mem_en[0], mem_we[0], if_ready[0], dm_ready[0], gnt_dm[0]});
      end
      total++;
      if (mem_addr[0] !== '0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr[0]); end
      total++;
      if (mem_wdata[0] !== '0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata[0]); end
      total++;
      if (if_rdata[0] !== '0) begin bad++; $display("FAIL reset_if_rdata got=%h exp=0", if_rdata[0]); end
      total++;
      if (dm_rdata[0] !== '0) begin bad++; $display("FAIL reset_dm_rdata got=%h exp=0", dm_rdata[0]); end
      total++;
      if (pipe_stall[0] !== 1'b0) begin bad++; $display("FAIL reset_stall_idle got=%b exp=0", pipe_stall[0]); end
      if_req = 1'b1;
      #1;
      total++;
      if (pipe_stall[0] !== 1'b1) begin bad++; $display("FAIL reset_stall_comb got=%b exp=1", pipe_stall[0]); end
      if_req = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_if_read();
      exp_t e;
      bit   done = 0;
      int   t0;
      do_reset();
      if_addr = 32'h0040_0000; if_req = 1'b1; t0 = cyc;
      sbq.push_back('{1'b0, mem_val(32'h0040_0000), 4});
      for (int n = 0; n < 12 && !done; n++) begin
         if (n > 0) tick();
         #1;
         total++;
         if (pipe_stall[0] !== (n < 4)) begin
            bad++; $display("FAIL if_read_stall n=%0d got=%b exp=%b", n, pipe_stall[0], (n < 4));
         end
         total++;
         if (mem_en[0] !== (n == 1)) begin
            bad++; $display("FAIL if_read_mem_en n=%0d got=%b exp=%b", n, mem_en[0], (n == 1));
         end
         if (n == 1) begin
            total++;
            if (mem_addr[0] !== 32'h0040_0000) begin
               bad++; $display("FAIL if_read_addr got=%h exp=00400000", mem_addr[0]);
            end
         end
         if (if_ready[0] === 1'b1 || dm_ready[0] === 1'b1) begin
            if (sbq.size() == 0) begin
               total++; bad++; $display("FAIL if_read_spurious_ready n=%0d", n);
            end else begin
               e = sbq.pop_front();
               total++;
               if ({dm_ready[0], if_ready[0]} !== 2'b01) begin
                  bad++; $display("FAIL if_read_owner got=%b exp=01", {dm_ready[0], if_ready[0]});
               end
               total++;
               if (cyc - t0 !== e.rdy) begin
                  bad++; $display("FAIL if_read_latency got=%0d exp=%0d", cyc - t0, e.rdy);
               end
               total++;
               if (if_rdata[0] !== e.data) begin
                  bad++; $display("FAIL if_read_data got=%h exp=%h", if_rdata[0], e.data);
               end
            end
            if_req = 1'b0;
            done = 1;
         end
      end
      if (!done) begin total++; bad++; $display("FAIL if_read_timeout no if_ready"); end
      tick();
      #1;
      total++;
      if ({if_ready[0], if_rdata[0]} !== {1'b0, 32'h2008_0005}) begin
         bad++; $display("FAIL if_read_hold got=%b/%h exp=0/20080005", if_ready[0], if_rdata[0]);
      end
   endtask

   task automatic test_priority();
      exp_t e;
      bit   done = 0;
      int   t0;
      do_reset();
      if_addr = 32'h0040_0000; if_req = 1'b1;
      dm_addr = 32'h1001_0000; dm_we = 1'b0; dm_req = 1'b1;
      t0 = cyc;
      sbq.push_back('{1'b1, mem_val(32'h1001_0000), 4});
      sbq.push_back('{1'b0, mem_val(32'h0040_0000), 9});
      for (int n = 0; n < 16 && !done; n++) begin
         if (n > 0) tick();
         #1;
         total++;
         if (mem_en[0] !== (n == 1 || n == 6)) begin
            bad++; $display("FAIL prio_mem_en n=%0d got=%b exp=%b", n, mem_en[0], (n == 1 || n == 6));
         end
         if (mem_en[0] === 1'b1) begin
            total++;
            if (gnt_dm[0] !== (n == 1)) begin
               bad++; $display("FAIL prio_gnt n=%0d got=%b exp=%b", n, gnt_dm[0], (n == 1));
            end
         end
         if (if_ready[0] === 1'b1 || dm_ready[0] === 1'b1) begin
            if (sbq.size() == 0) begin
               total++; bad++; $display("FAIL prio_spurious_ready n=%0d", n);
               done = 1;
            end else begin
               e = sbq.pop_front();
               total++;
               if ({dm_ready[0], if_ready[0]} !== (e.is_dm ? 2'b10 : 2'b01)) begin
                  bad++; $display("FAIL prio_owner n=%0d got=%b exp=%b", n,
                                  {dm_ready[0], if_ready[0]}, (e.is_dm ? 2'b10 : 2'b01));
               end
               total++;
               if (cyc - t0 !== e.rdy) begin
                  bad++; $display("FAIL prio_latency got=%0d exp=%0d", cyc - t0, e.rdy);
               end
               total++;
               if ((e.is_dm ? dm_rdata[0] : if_rdata[0]) !== e.data) begin
                  bad++; $display("FAIL prio_data dm=%b got=%h exp=%h", e.is_dm,
                                  (e.is_dm ? dm_rdata[0] : if_rdata[0]), e.data);
               end
               if (e.is_dm) begin
                  total++;
                  if (if_rdata[0] !== '0) begin
                     bad++; $display("FAIL prio_if_rdata_disturbed got=%h exp=0", if_rdata[0]);
                  end
                  dm_req = 1'b0;
               end else begin
                  total++;
                  if (dm_rdata[0] !== mem_val(32'h1001_0000)) begin
                     bad++; $display("FAIL prio_dm_rdata_disturbed got=%h exp=%h",
                                     dm_rdata[0], mem_val(32'h1001_0000));
                  end
                  if_req = 1'b0;
                  done = 1;
               end
            end
         end
      end
      if (!done) begin total++; bad++; $display("FAIL prio_timeout no if_ready"); end
      if_req = 1'b0; dm_req = 1'b0;
   endtask

   task automatic test_dm_write();
      exp_t e;
      bit   done = 0;
      int   t0;
      do_reset();
      dm_addr = 32'h1001_0004; dm_wdata = 32'hDEAD_BEEF; dm_we = 1'b1; dm_req = 1'b1;
      t0 = cyc;
      sbq.push_back('{1'b1, 32'h0, 4});
      for (int n = 0; n < 12 && !done; n++) begin
         if (n > 0) tick();
         #1;
         total++;
         if (mem_en[0] !== (n == 1)) begin
            bad++; $display("FAIL wr_mem_en n=%0d got=%b exp=%b", n, mem_en[0], (n == 1));
         end
         if (n == 1) begin
            total++;
            if ({mem_we[0], mem_addr[0], mem_wdata[0]} !== {1'b1, 32'h1001_0004, 32'hDEAD_BEEF}) begin
               bad++; $display("FAIL wr_issue got=%b/%h/%h exp=1/10010004/deadbeef",
                               mem_we[0], mem_addr[0], mem_wdata[0]);
            end
         end
         if (dm_ready[0] === 1'b1 || if_ready[0] === 1'b1) begin
            if (sbq.size() == 0) begin
               total++; bad++; $display("FAIL wr_spurious_ready n=%0d", n);
            end else begin
               e = sbq.pop_front();
               total++;
               if ({dm_ready[0], if_ready[0]} !== 2'b10) begin
                  bad++; $display("FAIL wr_owner got=%b exp=10", {dm_ready[0], if_ready[0]});
               end
               total++;
               if (cyc - t0 !== e.rdy) begin
                  bad++; $display("FAIL wr_latency got=%0d exp=%0d", cyc - t0, e.rdy);
               end
               total++;
               if (dm_rdata[0] !== e.data) begin
                  bad++; $display("FAIL wr_dm_rdata_changed got=%h exp=%h", dm_rdata[0], e.data);
               end
            end
            dm_req = 1'b0;
            done = 1;
         end
      end
      if (!done) begin total++; bad++; $display("FAIL wr_timeout no dm_ready"); end
      dm_we = 1'b0;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit   done = 0;
      int   t0;
      do_reset();
      if_addr = 32'h0040_0000; if_req = 1'b1;
      for (int n = 0; n < 12 && !done; n++) begin
         if (n > 0) tick();
         #1;
         if (if_ready[0] === 1'b1) begin if_req = 1'b0; done = 1; end
      end
      if (!done) begin total++; bad++; $display("FAIL rstmid_setup_timeout no if_ready"); end
      tick();
      if_addr = 32'h0040_0100; if_req = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      #1;
      total++;
      if (if_rdata[0] !== '0) begin bad++; $display("FAIL rstmid_if_rdata got=%h exp=0", if_rdata[0]); end
      total++;
      if (mem_addr[0] !== '0) begin bad++; $display("FAIL rstmid_mem_addr got=%h exp=0", mem_addr[0]); end
      total++;
      if ({mem_en[0], mem_we[0], if_ready[0], dm_ready[0], gnt_dm[0], dm_rdata[0]} !== '0) begin
         bad++; $display("FAIL rstmid_ctrl got=%b/%h exp=0/0",
                         {mem_en[0], mem_we[0], if_ready[0], dm_ready[0], gnt_dm[0]}, dm_rdata[0]);
      end
      tick();
      reset = 1'b0;
      t0 = cyc;
      sbq.push_back('{1'b0, mem_val(32'h0040_0100), 4});
      done = 0;
      for (int n = 0; n < 12 && !done; n++) begin
         if (n > 0) tick();
         #1;
         total++;
         if (mem_en[0] !== (n == 1)) begin
            bad++; $display("FAIL rstmid_mem_en n=%0d got=%b exp=%b", n, mem_en[0], (n == 1));
         end
         if (if_ready[0] === 1'b1) begin
            if (sbq.size() == 0) begin
               total++; bad++; $display("FAIL rstmid_spurious_ready n=%0d", n);
            end else begin
               e = sbq.pop_front();
               total++;
               if (cyc - t0 !== e.rdy) begin
                  bad++; $display("FAIL rstmid_latency got=%0d exp=%0d", cyc - t0, e.rdy);
               end
               total++;
               if (if_rdata[0] !== e.data) begin
                  bad++; $display("FAIL rstmid_data got=%h exp=%h", if_rdata[0], e.data);
               end
            end
            if_req = 1'b0;
            done = 1;
         end
      end
      if (!done) begin total++; bad++; $display("FAIL rstmid_timeout no if_ready"); end
   endtask

   task automatic test_starve();
      int   ngr;
      int   k = 0;
      logic exp_dm;
      do_reset();
      if_addr = 32'h0040_0000; if_req = 1'b1;
      dm_addr = 32'h1001_0000; dm_we = 1'b0; dm_req = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
      ngr = 5;
`else
      ngr = 20;
`endif
      for (int n = 0; n < ngr * 6 + 10 && k < ngr; n++) begin
         if (n > 0) tick();
         #1;
         if (mem_en[0] === 1'b1) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_dm = (k < 4);
`else
            exp_dm = 1'b1;
`endif
            total++;
            if (gnt_dm[0] !== exp_dm) begin
               bad++; $display("FAIL starve_grant k=%0d got=%b exp=%b", k, gnt_dm[0], exp_dm);
            end
            k++;
         end
      end
      if (k < ngr) begin total++; bad++; $display("FAIL starve_timeout grants=%0d exp=%0d", k, ngr); end
      if_req = 1'b0; dm_req = 1'b0;
   endtask

   task automatic test_latency();
      int got [NI];
      int t0;
      do_reset();
      for (int i = 0; i < NI; i++) got[i] = -1;
      if_addr = 32'h0040_0000; if_req = 1'b1; t0 = cyc;
      for (int n = 0; n < 12; n++) begin
         if (n > 0) tick();
         #1;
         if (n == 1) if_req = 1'b0;
         for (int i = 0; i < NI; i++) begin
            if (if_ready[i] === 1'b1 && got[i] < 0) begin
               got[i] = cyc - t0;
               total++;
               if (if_rdata[i] !== 32'h2008_0005) begin
                  bad++; $display("FAIL lat_data inst=%0d got=%h exp=20080005", i, if_rdata[i]);
               end
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         total++;
         if (got[i] !== 2 + lat_of(i)) begin
            bad++; $display("FAIL lat_ready inst=%0d mem_lat=%0d got=%0d exp=%0d",
                            i, lat_of(i), got[i], 2 + lat_of(i));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_if_read();
      test_priority();
      test_dm_write();
      test_reset_mid();
      test_starve();
      test_latency();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the single-ported unified memory between the pipelined CPU's instruction-fetch stage (IF) and data-memory stage (MEM). Each stage raises a level request. The block grants one requester at a time, drives a fixed-latency memory access, returns read data with a one-cycle ready pulse, and produces the pipeline stall signal. It sits between the CPU stage logic and the memory model loaded from the program data file.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..255
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending (used only with the macro)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_rdata  out  DATA_W  fetched word; registered, held until the next IF read completes
- if_ready  out  1  one-cycle completion pulse for IF
- dm_req  in  1  data request; held until dm_ready
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data; registered, held until the next dm read completes
- dm_ready  out  1  one-cycle completion pulse for dm
- mem_en  out  1  one-cycle access strobe
- mem_we  out  1  write enable; qualified by mem_en
- mem_addr  out  ADDR_W  registered access address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data
- gnt_dm  out  1  1 = the current or last grant went to dm
- pipe_stall  out  1  combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready)

## Operation
- FSM states:
  - IDLE to ISSUE on any request.
  - ISSUE to WAIT.
  - WAIT stays for MEM_LAT cycles, counted by lat_cnt, then goes to RESP.
  - RESP to IDLE.
- Requests are sampled only in IDLE. A request still high during RESP is the completing request and is ignored.
- Priority on entering IDLE with both requests high: dm wins, because the MEM-stage instruction is older.
- On the IDLE to ISSUE edge, the arbiter latches the selected addr, we, wdata and owner into mem_addr, mem_we, mem_wdata and gnt_dm. mem_en is 1 for exactly the ISSUE cycle.
- On the final WAIT edge, mem_rdata is captured into the owner's rdata register. The capture happens for reads only; writes leave dm_rdata unchanged.
- In RESP, exactly one of if_ready or dm_ready is 1, and it belongs to the owner.
- if_rdata and dm_rdata are independent registers. A dm access never disturbs if_rdata.
- Reset (asynchronous, at any point including mid-access):
  - state = IDLE; lat_cnt and the starvation counter = 0.
  - mem_en, mem_we, if_ready, dm_ready and gnt_dm = 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata = 0.
  - An interrupted access is abandoned, not replayed. A request still held after reset deasserts is re-arbitrated from IDLE.

## Timing
- Requester raises req in cycle 0 with the FSM in IDLE. The response then runs:
  - mem_en in cycle 1.
  - mem_rdata valid in cycle 1+MEM_LAT.
  - ready in cycle 2+MEM_LAT; rdata is valid from the same cycle.
- Earliest next grant: IDLE in cycle 3+MEM_LAT, next mem_en in cycle 4+MEM_LAT. Peak throughput is one access per MEM_LAT+3 cycles.
- Write latency is identical to read latency.
- pipe_stall has zero latency from the req inputs and drops in the ready cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 3-bit counter increments on each dm grant made while if_req is high.
  - The counter clears on any IF grant, or when if_req is low at a grant.
  - When the counter equals STARVE_MAX and both requests are high, IF is granted.
- Undefined: strict dm priority; IF can starve indefinitely.

## Test plan
- Single IF read, MEM_LAT=2, addr 0x00400000, memory returns 0x20080005 → mem_en in cycle 1, if_ready in cycle 4 with if_rdata=0x20080005, pipe_stall high in cycles 0–3.
- Simultaneous if_req and dm_req (dm read of 0x10010000) → dm granted first, dm_ready in cycle 4. IF granted in cycle 5 with mem_en in cycle 6, if_ready in cycle 9.
- dm write of 0xDEADBEEF to 0x10010004 → mem_en=1 and mem_we=1 in one cycle with matching addr/data, dm_ready in cycle 4, dm_rdata unchanged.
- Reset asserted in the WAIT cycle → same cycle: mem_en=0, readies 0, rdata regs 0. After release with if_req held, a new mem_en appears 1 cycle later.
- dm_req held high continuously with if_req high, with the macro defined → 4 dm grants, then 1 IF grant. Without the macro → no IF grant within 20 accesses.
- MEM_LAT=1 and MEM_LAT=5 → ready at cycles 3 and 7 respectively.
